// File: rtl/dmem_responder_if.sv
// dmem_responder_if: load/store request and response bundle between a core and a data memory
//  req_valid/req_ready  request handshake, a transfer happens when both are high
//  req_write            1 = store, 0 = load
//  req_addr/req_wdata   byte address (word aligned) and store data
//  resp_valid           one-cycle response strobe, no backpressure
//  resp_rdata/resp_err  load data (0 for stores/errors) and error flag
interface dmem_responder_if;
  logic req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic resp_valid, resp_err;
  logic [31:0] resp_rdata;
  modport master (output req_valid, req_write, req_addr, req_wdata,
                  input req_ready, resp_valid, resp_rdata, resp_err);
  modport slave (input req_valid, req_write, req_addr, req_wdata,
                 output req_ready, resp_valid, resp_rdata, resp_err);
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: word-organised data memory target with WAIT_STATES cycles of response latency
//  clk    rising-edge clock for all state
//  reset  asynchronous active-high; clears control state, leaves RAM contents alone
//  bus    slave side of dmem_responder_if (request handshake in, one-cycle response out)
module dmem_responder #(
  parameter int DEPTH = 64,
  parameter int WAIT_STATES = 2
) (
  input logic clk,
  input logic reset,
  dmem_responder_if.slave bus
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, next;
  logic [3:0] cnt;
  logic wr_q, rdata_en, err_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [31:0] mem [DEPTH];
  logic accept, enter_resp, op_wr, op_err;
  logic [31:0] op_addr, op_wdata;
  logic [AW-1:0] idx;
  assign bus.req_ready = state == IDLE && !reset;
  assign bus.resp_valid = state == RESP;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err = err_q;
  assign accept = bus.req_valid && bus.req_ready;
  always_comb begin
    next = state;
    if (state == IDLE && accept) next = WAIT_STATES == 0 ? RESP : WAIT;
    else if (state == WAIT && cnt == 4'd0) next = RESP;
    else if (state == RESP) next = IDLE;
  end
  // With zero wait states the memory operation happens on the accept edge,
  // so the live request is used instead of the latched copy.
  assign enter_resp = next == RESP;
  assign op_wr = state == IDLE ? bus.req_write : wr_q;
  assign op_addr = state == IDLE ? bus.req_addr : addr_q;
  assign op_wdata = state == IDLE ? bus.req_wdata : wdata_q;
  assign op_err = op_addr[1:0] != 2'b00 || {2'b00, op_addr[31:2]} >= 32'(DEPTH);
  assign idx = op_addr[AW+1:2];
  assign rdata_en = enter_resp && !op_wr && !op_err;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      wr_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= next;
      if (accept) begin
        cnt <= 4'(WAIT_STATES - 1);
        wr_q <= bus.req_write;
        addr_q <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end else if (state == WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
      rdata_q <= rdata_en ? mem[idx] : '0;
      err_q <= enter_resp && op_err;
    end
  end
  always_ff @(posedge clk)
    if (enter_resp && op_wr && !op_err) mem[idx] <= op_wdata;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized check of two responders (2 and 0 wait states) against a queue/array model
module tb_dmem_responder;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  logic v[2], w[2], rdy[2], rv[2], re[2];
  logic [31:0] a[2], d[2], rd[2];
  bit hold[2];
  int cyc = 0, checks = 0, errors = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {
    logic wr;
    logic [31:0] addr, data;
    int due;
  } txn_t;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  for (genvar g = 0; g < 2; g++) begin : u
    localparam int WS = g == 0 ? 2 : 0;
    dmem_responder_if bus ();
    dmem_responder #(.DEPTH(64), .WAIT_STATES(WS)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
    assign bus.req_valid = v[g];
    assign bus.req_write = w[g];
    assign bus.req_addr = a[g];
    assign bus.req_wdata = d[g];
    assign rdy[g] = bus.req_ready;
    assign rv[g] = bus.resp_valid;
    assign rd[g] = bus.resp_rdata;
    assign re[g] = bus.resp_err;
    txn_t q[$];
    txn_t t;
    logic [31:0] mm [64];
    bit known [64];
    bit prev_rv, bad;
    int last_acc = -1, wi;
    always @(negedge clk) begin
      if (reset) begin
        q.delete();
        prev_rv = 0;
        last_acc = -1;
        check("reset_ready", 32'(rdy[g]), 0);
        check("reset_resp_valid", 32'(rv[g]), 0);
        check("reset_rdata", rd[g], 0);
      end else begin
        if (rv[g]) begin
          if (q.size() == 0) check("unexpected_resp", 1, 0);
          else begin
            t = q.pop_front();
            wi = int'(t.addr / 4);
            bad = (t.addr % 4 != 0) || (wi >= 64);
            check("resp_latency", cyc, t.due);
            check("resp_err", 32'(re[g]), 32'(bad));
            if (bad || t.wr) check("resp_rdata_zero", rd[g], 0);
            else if (known[wi]) check("load_data", rd[g], mm[wi]);
            if (!bad && t.wr) begin
              mm[wi] = t.data;
              known[wi] = 1;
            end
          end
        end else begin
          if (prev_rv) begin
            check("post_resp_rdata", rd[g], 0);
            check("post_resp_err", 32'(re[g]), 0);
          end
          if (q.size() > 0 && cyc > q[0].due) begin
            check("resp_missing", 0, 1);
            void'(q.pop_front());
          end
        end
        prev_rv = rv[g];
        if (!hold[g]) last_acc = -1;
        if (v[g] && rdy[g]) begin
          q.push_back('{wr: w[g], addr: a[g], data: d[g], due: cyc + 1 + WS});
          if (last_acc >= 0) check("accept_gap", cyc + 1 - last_acc, WS + 2);
          if (hold[g]) last_acc = cyc + 1;
        end
      end
    end
  end
  task automatic wait_accept(int i);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rdy[i] && n < 50);
    check("accept_seen", 32'(rdy[i]), 1);
    @(posedge clk);
    #1;
  endtask
  task automatic send(int i, bit wr, logic [31:0] addr, logic [31:0] data);
    v[i] = 1'b1;
    w[i] = wr;
    a[i] = addr;
    d[i] = data;
    wait_accept(i);
    v[i] = 1'b0;
    w[i] = 1'($urandom);
    a[i] = $urandom;
    d[i] = $urandom;
  endtask
  task automatic op(int i, bit wr, logic [31:0] addr, logic [31:0] data);
    send(i, wr, addr, data);
    repeat (5) @(posedge clk);
    #1;
  endtask
  task automatic burst(int i);
    hold[i] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      v[i] = 1'b1;
      w[i] = 1'b1;
      a[i] = 32'(k * 4);
      d[i] = $urandom;
      wait_accept(i);
    end
    v[i] = 1'b0;
    hold[i] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] rand_addr();
    int r = $urandom_range(0, 9);
    return r < 7 ? 32'($urandom_range(0, 7)) * 4 :
           r == 7 ? 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(1, 3)) :
           r == 8 ? 32'($urandom_range(64, 1000)) * 4 : 32'd252;
  endfunction
  initial begin
    for (int i = 0; i < 2; i++) begin
      v[i] = 1'b0;
      w[i] = 1'b0;
      a[i] = '0;
      d[i] = '0;
      hold[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      op(i, 1, 100, 7);
      op(i, 0, 100, 0);
      op(i, 1, 96, 32'h11);
      op(i, 1, 0, 32'h22);
      op(i, 0, 32'h62, 0);
      op(i, 1, 32'h62, 32'h55);
      op(i, 1, 256, 32'h66);
      op(i, 0, 96, 0);
      op(i, 0, 0, 0);
      burst(i);
      for (int k = 0; k < 4; k++) op(i, 0, 32'(k * 4), 0);
      op(i, 0, 100, 0);
      repeat (40) op(i, 1'($urandom), rand_addr(), $urandom);
    end
    op(0, 1, 96, 32'h1234);
    send(0, 1, 96, 32'hDEAD);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    op(0, 0, 96, 0);
    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
